underdesigned_multiplier_pipe: RTL and testbench
================================================

UNDERDESIGNED_MULTIPLIER_PIPE -- requirements
Module: underdesigned_multiplier_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width; legal values are even, 4..32.
REQ-002 SHALL have parameter CNT_W, default 16, width of the approximation-event counter.
REQ-003 SHALL have port clk_i, input, 1, sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid_i, input, 1, operand pair present.
REQ-006 SHALL have port in_ready_o, output, 1, block accepts the operand pair this cycle.
REQ-007 SHALL have port op1_i, input, WIDTH, unsigned multiplicand.
REQ-008 SHALL have port op2_i, input, WIDTH, unsigned multiplier.
REQ-009 SHALL have port exact_i, input, 1, per-transaction mode: 1 selects exact, 0 selects underdesigned.
REQ-010 SHALL have port out_valid_o, output, 1, product available.
REQ-011 SHALL have port out_ready_i, input, 1, consumer takes the product.
REQ-012 SHALL have port product_o, output, 2*WIDTH, unsigned product.
REQ-013 SHALL have port approx_hit_o, output, 1, the current product differs from exact due to approximation.
REQ-014 SHALL have port approx_cnt_o, output, CNT_W, saturating count of delivered products with approx_hit set.

Function
REQ-015 SHALL split each operand into WIDTH/2 2-bit digits and form all (WIDTH/2)^2 digit products.
REQ-016 In underdesigned mode, the digit product SHALL be 3 bits: 3x3 yields 7; every other pair is exact.
REQ-017 In exact mode, the digit product SHALL be 4 bits: 3x3 yields 9.
REQ-018 Each digit product SHALL be weighted by 4^(i+j) and summed with no truncation to 2*WIDTH bits.
REQ-019 approx_hit SHALL be 1 iff the mode is underdesigned and at least one digit pair is (3,3).
REQ-020 SHALL be a 3-stage pipeline.
- S1: register operands, mode, and digit products.
- S2: carry-save reduce to two vectors.
- S3: final carry-propagate add, registered output.
REQ-021 Latency SHALL be 3 cycles from input handshake to out_valid_o with no backpressure; throughput SHALL be 1 per cycle.
REQ-022 Input handshake occurs when in_valid_i and in_ready_o are both 1; output handshake occurs when out_valid_o and out_ready_i are both 1.
REQ-023 in_ready_o SHALL equal (!out_valid_o || out_ready_i); the pipeline advances as a whole only when in_ready_o is 1, otherwise every stage holds.
REQ-024 Bubbles SHALL propagate as per-stage valid bits; a bubble never asserts out_valid_o.
REQ-025 While out_valid_o=1 and out_ready_i=0, product_o and approx_hit_o SHALL stay stable.
REQ-026 approx_cnt_o SHALL increment by 1 on each output handshake with approx_hit_o=1 and saturate at all-ones with no wrap.
REQ-027 Operands and mode SHALL be ignored when no input handshake occurs.

Reset
REQ-028 On rst_i=1, all stage valids, out_valid_o, product_o, approx_hit_o, and approx_cnt_o SHALL clear to 0 asynchronously; in_ready_o SHALL be 1 during and after reset.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight transactions, with no output handshake for them.

Configuration
REQ-030 Macro UDM_EXACT_MODE_EN: when defined, exact_i SHALL be honoured per REQ-017.
REQ-031 When UDM_EXACT_MODE_EN is undefined, exact_i SHALL be ignored, all products are underdesigned, and the exact-mode digit logic SHALL not be built.

Structure
REQ-032 Package udm_pkg SHALL hold the digit-product function, the digit-count constant, and the stage-valid typedef.
REQ-033 A sub-module udm_digit_mult SHALL implement one 2x2 digit product with mode input and a hit flag; it is instantiated (WIDTH/2)^2 times.

Verification
REQ-034 WIDTH=8, 255x255, exact_i=0 -> product 50575, approx_hit 1, 3 cycles later; the same operands with exact_i=1 -> 65025, approx_hit 0.
REQ-035 WIDTH=8, 3x3 with exact_i=0 -> 7 and hit 1; 2x3 -> 6 and hit 0; 0x255 -> 0 and hit 0.
REQ-036 Back-to-back stream of 10 operand pairs with out_ready_i=1 -> 10 results in order on consecutive cycles.
REQ-037 out_ready_i low for 5 cycles with a full pipe -> in_ready_o=0, output held stable, no loss or duplication after release.
REQ-038 CNT_W=2, five approximate results delivered -> approx_cnt_o sticks at 3.
REQ-039 Assert rst_i with 3 transactions in flight -> outputs 0 immediately, no stale results after release; without UDM_EXACT_MODE_EN, 255x255 with exact_i=1 -> 50575.

Source files
------------

// File: rtl/udm_pkg.sv
// Shared definitions for the underdesigned multiplier pipe.
// The UDM_EXACT_MODE_EN macro decides whether callers may request the exact 3x3 digit product.
package udm_pkg;

  localparam int UDM_DIGIT_W = 2;

  typedef struct packed {
    logic s1;
    logic s2;
    logic s3;
  } udm_valid_t;

  function automatic int udm_num_digits(input int width);
    return width / UDM_DIGIT_W;
  endfunction

  // 3x3 collapses to 7 so the underdesigned product fits in 3 bits.
  function automatic logic [3:0] udm_digit_prod(input logic [1:0] a, input logic [1:0] b,
                                                input logic exact);
    logic [3:0] p;
    p = {2'b00, a} * {2'b00, b};
    if ((a == 2'd3) && (b == 2'd3) && !exact) p = 4'd7;
    return p;
  endfunction

endpackage

// File: rtl/udm_digit_mult.sv
// One 2x2-bit digit multiplier with mode select and approximation flag.
// Exact mode is only built when UDM_EXACT_MODE_EN is defined.
module udm_digit_mult
  import udm_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       exact,
  output logic [3:0] prod,
  output logic       hit
);

  logic both_max;
  assign both_max = (a == 2'd3) && (b == 2'd3);

`ifdef UDM_EXACT_MODE_EN
  assign prod = udm_digit_prod(a, b, exact);
  assign hit  = both_max && !exact;
`else
  logic unused_exact;
  assign unused_exact = exact;
  assign prod = udm_digit_prod(a, b, 1'b0);
  assign hit  = both_max;
`endif

endmodule

// File: rtl/underdesigned_multiplier_pipe.sv
// Three-stage underdesigned multiplier: digit products, carry-save reduce, final add.
// Define UDM_EXACT_MODE_EN to honour exact_i; otherwise every product is underdesigned.
module underdesigned_multiplier_pipe
  import udm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   op1_i,
  input  logic [WIDTH-1:0]   op2_i,
  input  logic               exact_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] product_o,
  output logic               approx_hit_o,
  output logic [CNT_W-1:0]   approx_cnt_o
);

  localparam int ND = udm_num_digits(WIDTH);
  localparam int NP = ND * ND;
  localparam int PW = 2 * WIDTH;

  udm_valid_t       valid_q;
  logic             advance;
  logic             mode;
  logic [3:0]       dp_comb [NP];
  logic [NP-1:0]    hit_comb;
  logic [3:0]       dp_q [NP];
  logic             hit1_q;
  logic [PW-1:0]    csa_s;
  logic [PW-1:0]    csa_c;
  logic [PW-1:0]    sum2_q;
  logic [PW-1:0]    car2_q;
  logic             hit2_q;

`ifdef UDM_EXACT_MODE_EN
  assign mode = exact_i;
`else
  logic unused_exact_i;
  assign unused_exact_i = exact_i;
  assign mode = 1'b0;
`endif

  assign out_valid_o = valid_q.s3;
  assign in_ready_o  = !valid_q.s3 || out_ready_i;
  assign advance     = in_ready_o;

  for (genvar i = 0; i < ND; i++) begin : g_row
    for (genvar j = 0; j < ND; j++) begin : g_col
      udm_digit_mult u_digit (
        .a     (op1_i[UDM_DIGIT_W*i +: UDM_DIGIT_W]),
        .b     (op2_i[UDM_DIGIT_W*j +: UDM_DIGIT_W]),
        .exact (mode),
        .prod  (dp_comb[i*ND+j]),
        .hit   (hit_comb[i*ND+j])
      );
    end
  end

  // Modulo-2^PW carry-save accumulation is safe: the true sum always fits in PW bits.
  always_comb begin
    logic [PW-1:0] pp;
    logic [PW-1:0] s;
    logic [PW-1:0] c;
    pp    = '0;
    s     = '0;
    c     = '0;
    csa_s = '0;
    csa_c = '0;
    for (int i = 0; i < ND; i++) begin
      for (int j = 0; j < ND; j++) begin
        pp    = PW'(dp_q[i*ND+j]) << (UDM_DIGIT_W * (i + j));
        s     = csa_s ^ csa_c ^ pp;
        c     = ((csa_s & csa_c) | (csa_s & pp) | (csa_c & pp)) << 1;
        csa_s = s;
        csa_c = c;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q      <= '0;
      hit1_q       <= 1'b0;
      sum2_q       <= '0;
      car2_q       <= '0;
      hit2_q       <= 1'b0;
      product_o    <= '0;
      approx_hit_o <= 1'b0;
      for (int k = 0; k < NP; k++) dp_q[k] <= '0;
    end else if (advance) begin
      valid_q.s1 <= in_valid_i;
      if (in_valid_i) begin
        dp_q   <= dp_comb;
        hit1_q <= |hit_comb;
      end
      valid_q.s2 <= valid_q.s1;
      if (valid_q.s1) begin
        sum2_q <= csa_s;
        car2_q <= csa_c;
        hit2_q <= hit1_q;
      end
      valid_q.s3 <= valid_q.s2;
      if (valid_q.s2) begin
        product_o    <= sum2_q + car2_q;
        approx_hit_o <= hit2_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      approx_cnt_o <= '0;
    end else if (out_valid_o && out_ready_i && approx_hit_o && (approx_cnt_o != '1)) begin
      approx_cnt_o <= approx_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_underdesigned_multiplier_pipe.sv
// Scoreboard bench for underdesigned_multiplier_pipe (WIDTH=8, CNT_W=2).
module tb_underdesigned_multiplier_pipe;

  localparam int WIDTH   = 8;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready_o;
  logic [WIDTH-1:0]   op1;
  logic [WIDTH-1:0]   op2;
  logic               exact;
  logic               out_valid_o;
  logic               out_ready;
  logic [2*WIDTH-1:0] product_o;
  logic               approx_hit_o;
  logic [CNT_W-1:0]   approx_cnt_o;

  typedef struct {
    logic [2*WIDTH-1:0] prod;
    logic               hit;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt_model = 0;
  int   run = 0;
  int   max_run = 0;
  int   pops = 0;

  underdesigned_multiplier_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready_o),
    .op1_i        (op1),
    .op2_i        (op2),
    .exact_i      (exact),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready),
    .product_o    (product_o),
    .approx_hit_o (approx_hit_o),
    .approx_cnt_o (approx_cnt_o)
  );

  always #5 clk = ~clk;

  // Exact product minus 2*4^(i+j) for every (3,3) digit pair in approximate mode.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic ex);
    exp_t r;
    int   p;
    logic eff_ex;
`ifdef UDM_EXACT_MODE_EN
    eff_ex = ex;
`else
    eff_ex = 1'b0;
`endif
    p = int'(a) * int'(b);
    r.hit = 1'b0;
    for (int i = 0; i < WIDTH/2; i++) begin
      for (int j = 0; j < WIDTH/2; j++) begin
        if (a[2*i +: 2] == 2'd3 && b[2*j +: 2] == 2'd3 && !eff_ex) begin
          p = p - 2 * (4 ** (i + j));
          r.hit = 1'b1;
        end
      end
    end
    r.prod = p[2*WIDTH-1:0];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic e);
    int   guard;
    logic acc;
    in_valid = 1'b1;
    op1 = a;
    op2 = b;
    exact = e;
    guard = 0;
    do begin
      @(negedge clk);
      acc = in_ready_o;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 50);
    chk("send_accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      cnt_model = 0;
      run = 0;
    end else begin
      chk("approx_cnt", 32'(approx_cnt_o), 32'(cnt_model));
      run = out_valid_o ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (out_valid_o && sb.size() == 0) begin
        chk("spurious_out_valid", 32'(out_valid_o), 32'd0);
      end else if (out_valid_o && out_ready) begin
        e = sb.pop_front();
        chk("product", 32'(product_o), 32'(e.prod));
        chk("approx_hit", 32'(approx_hit_o), 32'(e.hit));
        if (e.hit && cnt_model < CNT_MAX) cnt_model++;
        pops++;
      end
      if (in_valid && in_ready_o) sb.push_back(model(op1, op2, exact));
    end
  end

  initial begin
    exp_t ea;
    int   guard;
    logic acc;
    int   pops0;

    rst = 1'b1;
    in_valid = 1'b0;
    op1 = '0;
    op2 = '0;
    exact = 1'b0;
    out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_product", 32'(product_o), 32'd0);
    chk("rst_hit", 32'(approx_hit_o), 32'd0);
    chk("rst_cnt", 32'(approx_cnt_o), 32'd0);
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // latency: valid appears in the third cycle after the handshake
    send(8'd255, 8'd255, 1'b0);
    @(negedge clk);
    chk("lat_c1", 32'(out_valid_o), 32'd0);
    @(negedge clk);
    chk("lat_c2", 32'(out_valid_o), 32'd0);
    @(negedge clk);
    chk("lat_c3", 32'(out_valid_o), 32'd1);
    chk("lat_prod_255", 32'(product_o), 32'd50575);
    @(posedge clk);
    #1;

    send(8'd255, 8'd255, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
`ifdef UDM_EXACT_MODE_EN
    chk("exact_255", 32'(product_o), 32'd65025);
`else
    chk("ignored_exact_255", 32'(product_o), 32'd50575);
`endif
    @(posedge clk);
    #1;

    send(8'd3, 8'd3, 1'b0);
    send(8'd2, 8'd3, 1'b0);
    send(8'd0, 8'd255, 1'b0);
    send(8'hCF, 8'h3B, 1'b1);
    send(8'hF3, 8'hFF, 1'b0);
    repeat (5) @(posedge clk);
    #1;

    max_run = 0;
    pops0 = pops;
    for (int k = 0; k < 10; k++)
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("stream_count", 32'(pops - pops0), 32'd10);
    chk("stream_consecutive", 32'(max_run >= 10), 32'd1);
    @(posedge clk);
    #1;

    // backpressure with a full pipe
    out_ready = 1'b0;
    ea = model(8'hB7, 8'hEE, 1'b0);
    send(8'hB7, 8'hEE, 1'b0);
    send(8'h12, 8'h34, 1'b0);
    send(8'hFF, 8'h0F, 1'b0);
    in_valid = 1'b1;
    op1 = 8'h77;
    op2 = 8'h3C;
    exact = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready_o), 32'd0);
      chk("stall_out_valid", 32'(out_valid_o), 32'd1);
      chk("stall_product", 32'(product_o), 32'(ea.prod));
      chk("stall_hit", 32'(approx_hit_o), 32'(ea.hit));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      acc = in_ready_o;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 50);
    chk("release_accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("bp_drained", 32'(sb.size()), 32'd0);

    // reset with three transactions in flight
    send(8'hFF, 8'hFF, 1'b0);
    send(8'h33, 8'h33, 1'b0);
    send(8'h0F, 8'hF0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("mid_rst_product", 32'(product_o), 32'd0);
    chk("mid_rst_hit", 32'(approx_hit_o), 32'd0);
    chk("mid_rst_cnt", 32'(approx_cnt_o), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready_o), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_no_stale", 32'(out_valid_o), 32'd0);
    end
    @(posedge clk);
    #1;

    // counter saturation: five approximate results
    for (int k = 0; k < 5; k++) send(8'd3, 8'd3, 1'b0);
    send(8'd2, 8'd3, 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("cnt_saturated", 32'(approx_cnt_o), 32'(CNT_MAX));
    chk("final_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
